// File: rtl/score_feeder_pkg.sv
// Shared constants, FSM encoding and slot helper for the score feeder and its packer.
// Sizes match the class-score sorter (10 x 16-bit signed, 4-bit index).
package score_feeder_pkg;

  localparam int N_CLASS     = 10;
  localparam int DW          = 16;
  localparam int IDX_W       = 4;
  localparam int LOAD_CYCLES = 2;
  localparam int SETTLE      = 10;
  localparam int TIMEOUT     = 64;

  localparam int CNT_W    = $clog2(N_CLASS + 1);
  localparam int LOAD_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  // Element 0 sits in the MSBs, so element k starts at this bit.
  function automatic int slot_lsb(input int k);
    return DW * (N_CLASS - 1 - k);
  endfunction

endpackage

// File: rtl/score_feeder_packer.sv
// score_packer: fill counter plus slot write of incoming scores into the sorter's packed vector.
// The vector is held untouched between frames; clear only rewinds the fill counter.
module score_packer
  import score_feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_data,
  output logic [N_CLASS*DW-1:0] data,
  output logic                  last,
  output logic                  full
);

  logic [CNT_W-1:0] count;

  assign last = (count == CNT_W'(N_CLASS - 1));
  assign full = (count == CNT_W'(N_CLASS));

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (wr_en && !full) begin
      for (int k = 0; k < N_CLASS; k++) begin
        if (count == CNT_W'(k)) begin
          data[slot_lsb(k) +: DW] <= wr_data;
        end
      end
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_feeder.sv
// score_feeder: collects one frame of class scores, drives the sorter load/complete protocol
// and hands the winning index and score to the consumer over a valid/ready handshake.
module score_feeder
  import score_feeder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic [N_CLASS*DW-1:0] sort_data,
  output logic                  sort_load,
  input  logic                  sort_complete,
  input  logic [IDX_W-1:0]      sort_index,
  input  logic [DW-1:0]         sort_max,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDX_W-1:0]      res_index,
  output logic [DW-1:0]         res_score,
  output logic                  res_err
);

  localparam logic [LOAD_W-1:0]   LOAD_LAST   = LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  state_t state, state_next;

  logic [LOAD_W-1:0]   load_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  logic accept;
  logic clear;
  logic last;
  logic full;

  score_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (in_data),
    .data    (sort_data),
    .last    (last),
    .full    (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // sort_complete is only looked at in WAIT; a level left over from the previous frame is harmless.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    sort_load  = 1'b0;
    res_valid  = 1'b0;
    clear      = 1'b0;
    case (state)
      ST_COLLECT: begin
        in_ready = !full;
        accept   = in_valid && !full;
        if (accept && last) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sort_load = 1'b1;
        if (load_cnt == LOAD_LAST) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sort_complete) begin
          state_next = ST_SETTLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = ST_RESULT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_RESULT;
        end
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          clear      = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  // Each counter runs only while its state persists and is back at zero on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt   <= '0;
      wait_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      load_cnt   <= (state == ST_LOAD   && state_next == ST_LOAD)   ? load_cnt + LOAD_W'(1)     : '0;
      wait_cnt   <= (state == ST_WAIT   && state_next == ST_WAIT)   ? wait_cnt + WAIT_W'(1)     : '0;
      settle_cnt <= (state == ST_SETTLE && state_next == ST_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_index <= '0;
      res_score <= '0;
      res_err   <= 1'b0;
    end else if (state == ST_WAIT && state_next == ST_RESULT) begin
      res_index <= '0;
      res_score <= '0;
      res_err   <= 1'b1;
    end else if (state == ST_SETTLE && state_next == ST_RESULT) begin
      res_index <= sort_index;
      res_score <= sort_max;
      res_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_score_feeder.sv
// Bench for score_feeder: table of frames with hand-computed results plus directed
// sequences for hold, timeout, mid-frame reset and back-to-back frames.
module tb_score_feeder;
  import score_feeder_pkg::*;

  localparam int SORT_LAT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [15:0]    in_data;
  logic [159:0]   sort_data;
  logic           sort_load;
  logic           sort_complete;
  logic [3:0]     sort_index;
  logic [15:0]    sort_max;
  logic           res_valid;
  logic           res_ready;
  logic [3:0]     res_index;
  logic [15:0]    res_score;
  logic           res_err;

  typedef struct {
    logic [15:0]  beats [10];
    logic [159:0] exp_data;
    logic [3:0]   exp_idx;
    logic [15:0]  exp_score;
    logic         exp_err;
    bit           toggle;
    int           hold;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int failures = 0;
  int load_run = 0;
  int last_load_run = 0;
  int ready_viol = 0;
  int frames_sent = 0;
  int frames_done = 0;
  bit sorter_en;
  bit ok_a, ok_b;
  int c, w;

  logic [159:0] model_data = '0;
  int           model_lat = 0;
  bit           model_armed = 1'b0;

  score_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .sort_data     (sort_data),
    .sort_load     (sort_load),
    .sort_complete (sort_complete),
    .sort_index    (sort_index),
    .sort_max      (sort_max),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_index     (res_index),
    .res_score     (res_score),
    .res_err       (res_err)
  );

  always #5 clk = ~clk;

  // Sorter stand-in: latches on load, raises a level complete SORT_LAT cycles after load ends.
  function automatic logic [19:0] argmax(input logic [159:0] d);
    logic signed [15:0] best;
    logic signed [15:0] e;
    logic [3:0] bi;
    best = d[159 -: 16];
    bi = 4'd0;
    for (int k = 1; k < 10; k++) begin
      e = d[159 - 16 * k -: 16];
      if (e > best) begin
        best = e;
        bi = 4'(k);
      end
    end
    return {bi, best};
  endfunction

  assign {sort_index, sort_max} = argmax(model_data);

  always @(posedge clk) begin
    if (rst || !sorter_en) begin
      sort_complete <= 1'b0;
      model_armed   <= 1'b0;
      model_lat     <= 0;
    end else if (sort_load) begin
      model_data    <= sort_data;
      model_armed   <= 1'b1;
      model_lat     <= 0;
      sort_complete <= 1'b0;
    end else if (model_armed && !sort_complete) begin
      if (model_lat == SORT_LAT - 1) sort_complete <= 1'b1;
      model_lat <= model_lat + 1;
    end
  end

  always @(posedge clk) begin
    if (res_valid && res_ready) frames_done <= frames_done + 1;
  end

  always @(negedge clk) begin
    if (sort_load) begin
      load_run <= load_run + 1;
    end else if (load_run != 0) begin
      last_load_run <= load_run;
      load_run <= 0;
    end
    if ((frames_sent != frames_done) && in_ready) ready_viol <= ready_viol + 1;
  end

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int v, input int nbeats);
    int k = 0;
    int cyc = 0;
    bit phase = 1'b1;
    bit fire;
    while (k < nbeats && cyc < 400) begin
      @(negedge clk);
      in_valid = vecs[v].toggle ? phase : 1'b1;
      in_data  = vecs[v].beats[k];
      phase    = !phase;
      fire     = in_valid && in_ready;
      @(posedge clk);
      if (fire) begin
        k++;
        if (k == 10) frames_sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput($sformatf("v%0d_beats_accepted", v), 160'(k), 160'(nbeats));
  endtask

  task automatic waitResult(output bit ok);
    int cnt = 0;
    while (!res_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    ok = res_valid;
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL result_timeout: res_valid=0 after %0d cycles, required 1", cnt);
    end
  endtask

  task automatic checkResult(input int v);
    checkOutput($sformatf("v%0d_sort_data", v), sort_data, vecs[v].exp_data);
    checkOutput($sformatf("v%0d_res_index", v), 160'(res_index), 160'(vecs[v].exp_idx));
    checkOutput($sformatf("v%0d_res_score", v), 160'(res_score), 160'(vecs[v].exp_score));
    checkOutput($sformatf("v%0d_res_err", v), 160'(res_err), 160'(vecs[v].exp_err));
    checkOutput($sformatf("v%0d_load_cycles", v), 160'(last_load_run), 160'(2));
  endtask

  task automatic handshake(input int hold);
    logic [3:0] i0;
    logic [15:0] s0;
    logic e0;
    logic [159:0] d0;
    int bad = 0;
    i0 = res_index;
    s0 = res_score;
    e0 = res_err;
    d0 = sort_data;
    res_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (res_index !== i0 || res_score !== s0 || res_err !== e0 ||
          sort_data !== d0 || res_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    if (hold > 0) checkOutput("hold_stable_violations", 160'(bad), 160'(0));
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("res_valid_after_handshake", 160'(res_valid), 160'(0));
    checkOutput("in_ready_after_handshake", 160'(in_ready), 160'(1));
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0].beats = '{16'h0005, 16'hFFFD, 16'h0064, 16'h0007, 16'h0000,
                      16'h8000, 16'h7FFF, 16'h000C, 16'hFFFF, 16'h0028};
    vecs[0].exp_data  = 160'h0005_FFFD_0064_0007_0000_8000_7FFF_000C_FFFF_0028;
    vecs[0].exp_idx   = 4'd6;
    vecs[0].exp_score = 16'h7FFF;
    vecs[0].exp_err   = 1'b0;
    vecs[0].toggle    = 1'b0;
    vecs[0].hold      = 20;

    vecs[1] = vecs[0];
    vecs[1].toggle = 1'b1;
    vecs[1].hold   = 0;

    vecs[2].beats = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[2].exp_data  = 160'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0001;
    vecs[2].exp_idx   = 4'd9;
    vecs[2].exp_score = 16'h0001;
    vecs[2].exp_err   = 1'b0;
    vecs[2].toggle    = 1'b0;
    vecs[2].hold      = 3;

    vecs[3].beats = '{16'h7FFF, 16'h8000, 16'hFFFE, 16'h0001, 16'h0002,
                      16'hFFFB, 16'h0100, 16'h8001, 16'h7FFE, 16'h0000};
    vecs[3].exp_data  = 160'h7FFF_8000_FFFE_0001_0002_FFFB_0100_8001_7FFE_0000;
    vecs[3].exp_idx   = 4'd0;
    vecs[3].exp_score = 16'h7FFF;
    vecs[3].exp_err   = 1'b0;
    vecs[3].toggle    = 1'b1;
    vecs[3].hold      = 0;

    vecs[4] = vecs[0];
    vecs[4].exp_idx   = 4'd0;
    vecs[4].exp_score = 16'h0000;
    vecs[4].exp_err   = 1'b1;
    vecs[4].hold      = 0;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    res_ready = 1'b0;
    sorter_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_in_ready", 160'(in_ready), 160'(1));
    checkOutput("reset_sort_data", sort_data, 160'(0));
    checkOutput("reset_sort_load", 160'(sort_load), 160'(0));
    checkOutput("reset_res_valid", 160'(res_valid), 160'(0));
    checkOutput("reset_res_index", 160'(res_index), 160'(0));
    checkOutput("reset_res_score", 160'(res_score), 160'(0));
    checkOutput("reset_res_err", 160'(res_err), 160'(0));

    for (int v = 0; v < 4; v++) begin
      applyStimulus(v, 10);
      waitResult(ok_a);
      if (ok_a) begin
        checkResult(v);
        handshake(vecs[v].hold);
      end
    end

    // Sorter never completes: expect exactly TIMEOUT cycles in WAIT, then an error result.
    sorter_en = 1'b0;
    applyStimulus(4, 10);
    c = 0;
    while (!sort_load && c < 50) begin
      @(negedge clk);
      c++;
    end
    while (sort_load && c < 50) begin
      @(negedge clk);
      c++;
    end
    w = 0;
    while (!res_valid && w < 200) begin
      w++;
      @(negedge clk);
    end
    checkOutput("timeout_wait_cycles", 160'(w), 160'(64));
    waitResult(ok_a);
    if (ok_a) begin
      checkResult(4);
      handshake(0);
    end
    sorter_en = 1'b1;

    // Reset in the middle of a frame, then a fresh frame must land in slots 0..9.
    applyStimulus(0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", 160'(in_ready), 160'(1));
    checkOutput("midrst_sort_data", sort_data, 160'(0));
    checkOutput("midrst_res_valid", 160'(res_valid), 160'(0));
    applyStimulus(2, 10);
    waitResult(ok_a);
    if (ok_a) begin
      checkResult(2);
      handshake(0);
    end

    // Back-to-back frames with the consumer always ready.
    res_ready = 1'b1;
    fork
      begin
        applyStimulus(0, 10);
        applyStimulus(3, 10);
      end
      begin
        waitResult(ok_a);
        if (ok_a) checkResult(0);
        @(negedge clk);
        waitResult(ok_b);
        if (ok_b) checkResult(3);
      end
    join
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("b2b_frames_done", 160'(frames_done), 160'(frames_sent));
    checkOutput("in_ready_while_busy", 160'(ready_viol), 160'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_feeder.md
Name: score_feeder

Overview:
- Write-side companion to the class-score sorter (10 × 16-bit signed, packed 160-bit vector, load/complete/index interface).
- Collects N_CLASS signed scores streamed from the PE output over a valid/ready handshake and packs them into the sorter's input vector.
- Drives the sorter's load protocol, waits for completion, then returns the winning class index and maximum score to the downstream consumer over a valid/ready handshake.

Parameters:
N_CLASS, 10, number of scores per frame (index width fixed at 4, N_CLASS ≤ 16)
DW, 16, score width, two's complement
LOAD_CYCLES, 2, consecutive cycles sort_load is held high
SETTLE, 10, cycles waited after sort_complete before sampling sort_index
TIMEOUT, 64, max WAIT cycles before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  score beat valid
in_ready  out  1  block accepts score beat
in_data  in  DW  signed score
sort_data  out  N_CLASS*DW  packed scores to sorter; element 0 in MSBs
sort_load  out  1  load strobe to sorter
sort_complete  in  1  sorter done flag (level)
sort_index  in  4  sorter's index of maximum
sort_max  in  DW  sorter output bits [DW-1:0] (largest element)
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_index  out  4  winning class index
res_score  out  DW  winning score
res_err  out  1  1 = sorter timed out; index/score invalid

Behaviour:
- Reset (rst=1 at posedge) → state COLLECT, fill count 0, sort_data 0, sort_load 0, res_valid 0, res_index 0, res_score 0, res_err 0, WAIT/SETTLE counters 0. Reset mid-frame discards the partial frame. in_ready is combinational: 1 exactly in COLLECT, including the cycle after reset.
- FSM states COLLECT, LOAD, WAIT, SETTLE, RESULT.
- COLLECT:
  - A beat is accepted when in_valid & in_ready.
  - Beat k (0-based) is written to sort_data[DW*(N_CLASS-k)-1 -: DW].
  - Fill count increments per beat. On beat N_CLASS-1 → LOAD next cycle; no further beats are accepted.
- LOAD:
  - sort_load = 1 for exactly LOAD_CYCLES consecutive cycles, then → WAIT.
  - sort_data must not change from the last accepted beat until leaving RESULT.
- WAIT:
  - sort_load = 0; cycle counter increments each cycle.
  - sort_complete = 1 → SETTLE.
  - Counter reaching TIMEOUT-1 without complete → RESULT with res_err=1, res_index=0, res_score=0.
  - If complete and timeout coincide, complete wins (err=0).
- SETTLE:
  - Waits SETTLE cycles so the sorter's index scan covers all elements.
  - On the last cycle, registers res_index=sort_index, res_score=sort_max, res_err=0, then → RESULT.
- RESULT:
  - res_valid = 1, with all res_* outputs stable while res_valid & !res_ready.
  - On res_valid & res_ready → COLLECT with fill count 0; res_valid drops the next cycle.
  - in_ready stays 0 throughout RESULT (no overlap of frames).
- Minimum frame latency, last score beat to res_valid: 1 + LOAD_CYCLES + (sorter latency) + SETTLE cycles.
- No arithmetic on scores; values pass through unchanged. Counters are sized with $clog2 of their limits and never wrap.
- sort_complete ignored in all states except WAIT.

Decomposition:
- Shared package:
  - State enum encoding (3 bits).
  - Constants N_CLASS=10, DW=16, IDX_W=4, matching the sorter.
  - Packed-vector slice helper function (element k → bit range).
- One natural sub-module, score_packer: fill counter plus shift/slot write into the N_CLASS*DW register, with a clear input and a full output. The FSM, handshakes and timeout stay in score_feeder.

Test Plan:
- Stream 10 beats 5,-3,100,7,0,-32768,32767,12,-1,40 with in_valid held high, checked against a sorter model → sort_data = 0x0005_FFFD_0064_0007_0000_8000_7FFF_000C_FFFF_0028; sort_load high exactly 2 cycles; res_index=6, res_score=32767, res_err=0.
- Same frame with in_valid toggled 1/0 every cycle → identical sort_data and result; in_ready=0 from LOAD until the res handshake.
- Hold res_ready=0 for 20 cycles after res_valid → res_index/res_score/res_err stable; release → res_valid low next cycle, in_ready=1.
- Tie sort_complete=0 → exactly 64 WAIT cycles, then res_valid=1 with res_err=1, res_index=0, res_score=0.
- Assert rst after beat 4 of a frame, then send a fresh frame of all -1 except beat 9=1 → no residue from the first frame; res_index=9, res_score=1.
- Two back-to-back frames with res_ready=1 → the second frame's beats are accepted only after the first result handshake; both results correct.
